dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache that sits directly downstream of the core's MEM+WB stage.
- Consumes the core's dcache_addr/dcache_din/dcache_we/dcache_re and returns dcache_dout and stall.
- Fills and evicts 128-bit lines over the Memory151 main-memory handshake (mem_req_*, mem_req_data_*, mem_resp_*).
- Replaces the behavioural dcache path inside Memory151.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_data_array.sv | 47 ++++
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding, request record and mask helper for the data cache.
package dcache_pkg;

   localparam int unsigned LineBits  = 128;
   localparam int unsigned LineBytes = LineBits / 8;
   localparam int unsigned OffsetW   = 4;
   localparam int unsigned WordSelW  = 2;
   localparam int unsigned MemAddrW  = 28;
   localparam int unsigned MemTagW   = 5;

   // FSM encoding kept as plain constants so older tools see a fixed layout.
   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StLookup   = 3'd1;
   localparam logic [2:0] StWb       = 3'd2;
   localparam logic [2:0] StFillReq  = 3'd3;
   localparam logic [2:0] StFillWait = 3'd4;
   localparam logic [2:0] StReplay   = 3'd5;

   // One accepted core request.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] din;
      logic [3:0]  we;
      logic        store;
   } req_t;

   // Place a word's 4-bit byte mask into its lane of a 16-byte line mask.
   function automatic logic [LineBytes-1:0] expand_mask(input logic [3:0]          we,
                                                        input logic [WordSelW-1:0] wsel);
      logic [LineBytes-1:0] m;
      m = {12'h000, we};
      return m << {wsel, 2'b00};
   endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line storage: LINES x 128 bits, per-byte write enables, registered read port.
module dcache_data_array
   import dcache_pkg::*;
#(
   parameter int unsigned LINES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [$clog2(LINES)-1:0] raddr_i,
   output logic [LineBits-1:0]      rdata_o,
   input  logic                     we_i,
   input  logic [$clog2(LINES)-1:0] waddr_i,
   input  logic [LineBytes-1:0]     wbe_i,
   input  logic [LineBits-1:0]      wdata_i
);

   logic [LineBits-1:0] mem_q [LINES];
   logic [LineBits-1:0] rdata_q, rdata_d;

   // Byte-masked line write.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int unsigned b = 0; b < LineBytes; b++) begin
            if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Same-cycle write to the read line is forwarded so the next read sees it.
   always_comb begin
      rdata_d = mem_q[raddr_i];
      if (we_i && (waddr_i == raddr_i)) begin
         for (int unsigned b = 0; b < LineBytes; b++) begin
            if (wbe_i[b]) rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
         end
      end
   end

   // Registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller (one beat per line).
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned LINES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          dcache_addr,
   input  logic [31:0]          dcache_din,
   input  logic [3:0]           dcache_we,
   input  logic                 dcache_re,
   output logic [31:0]          dcache_dout,
   output logic                 stall,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_rw,
   output logic [MemAddrW-1:0]  mem_req_addr,
   output logic [MemTagW-1:0]   mem_req_tag,
   output logic                 mem_req_data_valid,
   input  logic                 mem_req_data_ready,
   output logic [LineBits-1:0]  mem_req_data_bits,
   output logic [LineBytes-1:0] mem_req_data_mask,
   input  logic                 mem_resp_valid,
   input  logic [LineBits-1:0]  mem_resp_data,
   input  logic [MemTagW-1:0]   mem_resp_tag
);

   localparam int unsigned IdxW = $clog2(LINES);
   localparam int unsigned TagW = MemAddrW - IdxW;

   logic [2:0]         state_q, state_d;
   req_t               req_q;
   logic [TagW-1:0]    tag_q [LINES];
   logic [LINES-1:0]   valid_q, dirty_q;
   logic               wb_req_done_q, wb_req_done_d;
   logic               wb_data_done_q, wb_data_done_d;

   logic               new_req, accept, hit, victim_dirty, lookup;
   logic               store_hit, fill_we, wb_req_hs, wb_data_hs;
   logic [IdxW-1:0]    req_idx, rd_idx;
   logic [TagW-1:0]    req_tag;
   logic [LineBits-1:0]  line, fill_line, din_rep, arr_wdata;
   logic [LineBytes-1:0] store_mask, arr_wbe;
   logic [31:0]        line_word;
   logic               arr_we;
   logic               unused_ok;

   assign new_req      = dcache_re | (|dcache_we);
   assign req_idx      = req_q.addr[OffsetW +: IdxW];
   assign req_tag      = req_q.addr[31 -: TagW];
   assign lookup       = (state_q == StLookup);
   assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
   // A hitting LOOKUP and REPLAY both free the pipe, giving one request per cycle.
   assign accept       = new_req && ((state_q == StIdle) || (state_q == StReplay) ||
                                     (lookup && hit));
   assign store_hit    = lookup && hit && req_q.store;
   assign fill_we      = (state_q == StFillWait) && mem_resp_valid;
   assign wb_req_hs    = (state_q == StWb) && mem_req_valid && mem_req_ready;
   assign wb_data_hs   = (state_q == StWb) && mem_req_data_valid && mem_req_data_ready;

   assign store_mask = expand_mask(req_q.we, req_q.addr[3:2]);
   assign din_rep    = {4{req_q.din}};
   assign line_word  = line[{req_q.addr[3:2], 5'd0} +: 32];
   assign rd_idx     = accept ? dcache_addr[OffsetW +: IdxW] : req_idx;

   // Fill line with any pending store bytes merged in.
   always_comb begin
      fill_line = mem_resp_data;
      for (int unsigned b = 0; b < LineBytes; b++) begin
         if (req_q.store && store_mask[b]) fill_line[8*b +: 8] = din_rep[8*b +: 8];
      end
   end

   assign arr_we    = fill_we | store_hit;
   assign arr_wbe   = fill_we ? '1 : store_mask;
   assign arr_wdata = fill_we ? fill_line : din_rep;

   dcache_data_array #(
      .LINES(LINES)
   ) u_data (
      .clk    (clk),
      .reset  (reset),
      .raddr_i(rd_idx),
      .rdata_o(line),
      .we_i   (arr_we),
      .waddr_i(req_idx),
      .wbe_i  (arr_wbe),
      .wdata_i(arr_wdata)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (new_req) state_d = StLookup;
         StLookup: begin
            if (!hit)         state_d = victim_dirty ? StWb : StFillReq;
            else if (new_req) state_d = StLookup;
            else              state_d = StIdle;
         end
         StWb: begin
            if ((wb_req_done_q || wb_req_hs) && (wb_data_done_q || wb_data_hs))
               state_d = StFillReq;
         end
         StFillReq:  if (mem_req_ready) state_d = StFillWait;
         StFillWait: if (mem_resp_valid) state_d = StReplay;
         StReplay:   state_d = new_req ? StLookup : StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Eviction handshakes finish independently; the flags live only while in WB.
   assign wb_req_done_d  = (state_d == StWb) && (wb_req_done_q || wb_req_hs);
   assign wb_data_done_d = (state_d == StWb) && (wb_data_done_q || wb_data_hs);

   // FSM, request latch and eviction handshake tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         req_q          <= '0;
         wb_req_done_q  <= 1'b0;
         wb_data_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wb_req_done_q  <= wb_req_done_d;
         wb_data_done_q <= wb_data_done_d;
         if (accept) begin
            req_q.addr  <= dcache_addr;
            req_q.din   <= dcache_din;
            req_q.we    <= dcache_we;
            req_q.store <= |dcache_we;
         end
      end
   end

   // Tag/valid/dirty flops; kept out of the array so reset can clear them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int unsigned i = 0; i < LINES; i++) tag_q[i] <= '0;
      end else if (fill_we) begin
         valid_q[req_idx] <= 1'b1;
         dirty_q[req_idx] <= req_q.store;
         tag_q[req_idx]   <= req_tag;
      end else if (store_hit) begin
         dirty_q[req_idx] <= 1'b1;
      end
   end

   // Core and memory-side outputs.
   always_comb begin
      stall              = (state_q == StWb) || (state_q == StFillReq) ||
                           (state_q == StFillWait) || (lookup && !hit);
      dcache_dout        = '0;
      if (((lookup && hit) || (state_q == StReplay)) && !req_q.store) dcache_dout = line_word;
      mem_req_valid      = ((state_q == StWb) && !wb_req_done_q) || (state_q == StFillReq);
      mem_req_rw         = (state_q == StWb);
      mem_req_addr       = '0;
      if (state_q == StWb)      mem_req_addr = {tag_q[req_idx], req_idx};
      if (state_q == StFillReq) mem_req_addr = req_q.addr[31:OffsetW];
      mem_req_data_valid = (state_q == StWb) && !wb_data_done_q;
      mem_req_data_bits  = (state_q == StWb) ? line : '0;
   end

   assign mem_req_tag       = '0;
   assign mem_req_data_mask = '1;

   assign unused_ok = ^{mem_resp_tag, req_q.addr[1:0]};

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: line-level cache model plus memory responder.
module tb_dcache_ctrl;

   localparam int LINES = 64;

   typedef struct packed {
      logic         rw;
      logic [27:0]  addr;
      logic [127:0] data;
   } ev_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  dcache_addr, dcache_din, dcache_dout;
   logic [3:0]   dcache_we;
   logic         dcache_re, stall;
   logic         mem_req_valid, mem_req_ready, mem_req_rw;
   logic [27:0]  mem_req_addr;
   logic [4:0]   mem_req_tag, mem_resp_tag;
   logic         mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
   logic [127:0] mem_req_data_bits, mem_resp_data;
   logic [15:0]  mem_req_data_mask;

   always #5 clk = ~clk;

   dcache_ctrl #(
      .LINES(LINES)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .dcache_addr       (dcache_addr),
      .dcache_din        (dcache_din),
      .dcache_we         (dcache_we),
      .dcache_re         (dcache_re),
      .dcache_dout       (dcache_dout),
      .stall             (stall),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_rw        (mem_req_rw),
      .mem_req_addr      (mem_req_addr),
      .mem_req_tag       (mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid),
      .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits (mem_req_data_bits),
      .mem_req_data_mask (mem_req_data_mask),
      .mem_resp_valid    (mem_resp_valid),
      .mem_resp_data     (mem_resp_data),
      .mem_resp_tag      (mem_resp_tag)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Backing memory: unwritten lines read as a fixed pattern.
   logic [127:0] mem     [logic [27:0]];
   logic [127:0] ref_mem [logic [27:0]];

   function automatic logic [127:0] init_line(input logic [27:0] a);
      if (a == 28'h1) return {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      return {{a, 4'h3}, {a, 4'h2}, {a, 4'h1}, {a, 4'h0}} ^ {4{32'h9E370000}};
   endfunction

   function automatic logic [127:0] mem_rd(input logic [27:0] a);
      return mem.exists(a) ? mem[a] : init_line(a);
   endfunction

   function automatic logic [127:0] ref_rd(input logic [27:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   // Cache model: what each line holds per the write-back/write-allocate rules.
   logic         m_v [LINES];
   logic         m_d [LINES];
   logic [21:0]  m_t [LINES];
   logic [127:0] m_l [LINES];

   ev_t act_q[$];
   ev_t exp_q[$];

   // Responder / monitor state.
   int  rdy_dly = 0, drdy_dly = 0, resp_dly = 0;
   int  rq_age = 0, dq_age = 0, fill_cnt = 0;
   bit  fill_pending = 0, got_wa = 0, got_wd = 0, spur_en = 0;
   bit  exp_req_low = 0, exp_data_low = 0;
   bit  pv_rv = 0, pv_rr = 0, pv_dv = 0, pv_dr = 0, pv_rw = 0;
   logic [27:0]  pv_addr, wa, fill_addr;
   logic [127:0] pv_bits, wd;

   // Handshake monitor: logs memory traffic and checks valid/address stability.
   always @(posedge clk) begin
      if (!reset) begin
         if (pv_rv && !pv_rr) begin
            check("req_valid_hold", mem_req_valid, 1'b1);
            check("req_addr_hold", mem_req_addr, pv_addr);
            check("req_rw_hold", mem_req_rw, pv_rw);
         end
         if (pv_dv && !pv_dr) begin
            check("data_valid_hold", mem_req_data_valid, 1'b1);
            check("data_bits_hold", mem_req_data_bits, pv_bits);
         end
         if (exp_req_low)  check("req_valid_drop", mem_req_valid, 1'b0);
         if (exp_data_low) check("data_valid_drop", mem_req_data_valid, 1'b0);
         exp_req_low  = 0;
         exp_data_low = 0;
         if (mem_req_valid && mem_req_ready) begin
            ev_t e;
            rq_age = 0;
            check("req_tag_zero", mem_req_tag, 5'd0);
            if (mem_req_rw) begin
               wa     = mem_req_addr;
               got_wa = 1;
               if (!got_wd && !(mem_req_data_valid && mem_req_data_ready)) exp_req_low = 1;
            end else begin
               e.rw = 1'b0; e.addr = mem_req_addr; e.data = '0;
               act_q.push_back(e);
               fill_pending = 1;
               fill_addr    = mem_req_addr;
               fill_cnt     = resp_dly;
            end
         end
         if (mem_req_data_valid && mem_req_data_ready) begin
            dq_age = 0;
            check("data_mask_ones", mem_req_data_mask, 16'hFFFF);
            wd           = mem_req_data_bits;
            got_wd       = 1;
            exp_data_low = 1;
         end
         if (got_wa && got_wd) begin
            ev_t e;
            e.rw = 1'b1; e.addr = wa; e.data = wd;
            act_q.push_back(e);
            mem[wa] = wd;
            got_wa  = 0;
            got_wd  = 0;
         end
         pv_rv = mem_req_valid;      pv_rr = mem_req_ready;
         pv_addr = mem_req_addr;     pv_rw = mem_req_rw;
         pv_dv = mem_req_data_valid; pv_dr = mem_req_data_ready;
         pv_bits = mem_req_data_bits;
      end
   end

   // Memory responder: delayed readies and fill responses, driven on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         if (fill_pending) begin
            if (fill_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_rd(fill_addr);
               fill_pending   = 0;
            end else begin
               fill_cnt--;
            end
         end else if (spur_en && $urandom_range(0, 9) == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (mem_req_valid) rq_age++;
         else               rq_age = 0;
         if (mem_req_data_valid) dq_age++;
         else                    dq_age = 0;
         mem_req_ready      = mem_req_valid && (rq_age > rdy_dly);
         mem_req_data_ready = mem_req_data_valid && (dq_age > drdy_dly);
      end
   end

   task automatic clear_tb_state();
      for (int i = 0; i < LINES; i++) begin
         m_v[i] = 1'b0; m_d[i] = 1'b0; m_t[i] = '0; m_l[i] = '0;
      end
      act_q.delete(); exp_q.delete();
      fill_pending = 0; got_wa = 0; got_wd = 0; rq_age = 0; dq_age = 0;
      exp_req_low = 0; exp_data_low = 0;
      pv_rv = 0; pv_rr = 0; pv_dv = 0; pv_dr = 0;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0;
   endtask

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Issue one request (caller is at a falling edge with stall low), wait for its
   // response cycle and check it against the model. Inputs are left applied.
   task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                         input logic re, output logic [31:0] dout, output int stalls);
      int          idx, w;
      logic [21:0] tg;
      logic [27:0] vaddr;
      bit          exp_hit;
      logic [31:0] exp_dout;
      ev_t         e;
      idx = int'(a[9:4]);
      tg  = a[31:10];
      w   = int'(a[3:2]);
      exp_hit = m_v[idx] && (m_t[idx] == tg);
      if (!exp_hit) begin
         if (m_v[idx] && m_d[idx]) begin
            vaddr = {m_t[idx], a[9:4]};
            e.rw = 1'b1; e.addr = vaddr; e.data = m_l[idx];
            exp_q.push_back(e);
            ref_mem[vaddr] = m_l[idx];
         end
         e.rw = 1'b0; e.addr = a[31:4]; e.data = '0;
         exp_q.push_back(e);
         m_l[idx] = ref_rd(a[31:4]);
         m_v[idx] = 1'b1; m_t[idx] = tg; m_d[idx] = 1'b0;
      end
      if (|we) begin
         for (int k = 0; k < 4; k++)
            if (we[k]) m_l[idx][w*32 + k*8 +: 8] = din[k*8 +: 8];
         m_d[idx] = 1'b1;
      end
      exp_dout = m_l[idx][w*32 +: 32];

      act_q.delete();
      dcache_addr = a; dcache_we = we; dcache_din = din; dcache_re = re;
      @(negedge clk);
      stalls = 0;
      while (stall === 1'b1 && stalls < 300) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 300) begin
         errors++; checks++;
         $display("FAIL request_timeout: stall high for %0d cycles at addr %h, required low", stalls, a);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $fatal(1, "request never completed");
      end
      dout = dcache_dout;
      check("hit_no_stall", (stalls == 0), exp_hit);
      if (!exp_hit) check("miss_min_stall", (stalls >= 3), 1'b1);
      if (we == 4'b0) check("load_dout", dcache_dout, exp_dout);
      check("mem_event_count", act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check("mem_event_rw", act_q[i].rw, exp_q[i].rw);
         check("mem_event_addr", act_q[i].addr, exp_q[i].addr);
         if (exp_q[i].rw) check("mem_event_data", act_q[i].data, exp_q[i].data);
      end
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] dout;
      int          stalls, waited;
      reset = 1'b1;
      dcache_addr = '0; dcache_din = '0; dcache_we = '0; dcache_re = 1'b0;
      mem_resp_tag = 5'd3;
      clear_tb_state();
      repeat (2) @(negedge clk);
      check("reset_stall", stall, 1'b0);
      check("reset_dout", dcache_dout, 32'h0);
      check("reset_req_valid", mem_req_valid, 1'b0);
      check("reset_data_valid", mem_req_data_valid, 1'b0);
      reset = 1'b0;

      // Cold load miss, then hits and a store hit.
      do_req(32'h00000010, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("cold_miss_stalls", stalls, 3);
      check("cold_miss_dout", dout, 32'hAAAAAAAA);
      check("cold_fill_count", act_q.size(), 1);
      if (act_q.size() > 0) check("cold_fill_addr", act_q[0].addr, 28'h0000001);
      do_req(32'h00000014, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("hit_stalls", stalls, 0);
      check("hit_dout", dout, 32'hBBBBBBBB);
      do_req(32'h00000010, 4'b0011, 32'h00001234, 1'b0, dout, stalls);
      check("store_hit_stalls", stalls, 0);
      do_req(32'h00000010, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("store_merge_dout", dout, 32'hAAAA1234);
      check("store_no_traffic", act_q.size(), 0);

      // Dirty conflict: eviction of line 1 precedes the fill of line 0x41.
      dcache_re = 1'b0; dcache_we = '0;
      @(negedge clk);
      do_req(32'h00000410, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("evict_event_count", act_q.size(), 2);
      if (act_q.size() == 2) begin
         check("evict_first_rw", act_q[0].rw, 1'b1);
         check("evict_addr", act_q[0].addr, 28'h0000001);
         check("evict_data", act_q[0].data,
               {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAA1234});
         check("refill_rw", act_q[1].rw, 1'b0);
         check("refill_addr", act_q[1].addr, 28'h0000041);
      end

      // Slow command channel, data channel accepted first.
      do_req(32'h00000410, 4'b1111, 32'hFEEDF00D, 1'b0, dout, stalls);
      rdy_dly = 3; drdy_dly = 1;
      do_req(32'h00000010, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("slow_hs_stalls", stalls, 10);
      check("slow_hs_dout", dout, 32'hAAAA1234);
      rdy_dly = 0; drdy_dly = 0;

      // Reset while a fill response is outstanding.
      resp_dly = 5;
      act_q.delete();
      dcache_addr = 32'h00000800; dcache_we = '0; dcache_din = '0; dcache_re = 1'b1;
      waited = 0;
      while (act_q.size() == 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("reset_test_fill_seen", (act_q.size() > 0), 1'b1);
      @(negedge clk);
      check("fill_wait_stall", stall, 1'b1);
      reset = 1'b1;
      #1;
      check("midreset_stall", stall, 1'b0);
      check("midreset_dout", dcache_dout, 32'h0);
      check("midreset_req_valid", mem_req_valid, 1'b0);
      check("midreset_data_valid", mem_req_data_valid, 1'b0);
      dcache_re = 1'b0;
      clear_tb_state();
      resp_dly = 0;
      @(negedge clk);
      reset = 1'b0;
      do_req(32'h00000010, 4'b0000, 32'h0, 1'b1, dout, stalls);
      check("post_reset_stalls", stalls, 3);
      check("post_reset_dout", dout, 32'hAAAA1234);

      // Randomized traffic over a few conflicting sets.
      spur_en = 1;
      for (int n = 0; n < 300; n++) begin
         logic [21:0] tg;
         logic [3:0]  we;
         logic        re;
         logic [31:0] a;
         tg = 22'($urandom_range(0, 2) * 22'h1357);
         a  = {tg, 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
         re = (we == 4'b0) ? 1'b1 : 1'($urandom_range(0, 1));
         rdy_dly  = $urandom_range(0, 3);
         drdy_dly = $urandom_range(0, 3);
         resp_dly = $urandom_range(0, 3);
         do_req(a, we, $urandom(), re, dout, stalls);
         if ($urandom_range(0, 1) == 1) begin
            dcache_re = 1'b0; dcache_we = '0;
            @(negedge clk);
         end
      end
      dcache_re = 1'b0; dcache_we = '0;
      repeat (2) @(negedge clk);
      finish_now();
   end

endmodule
